// File: rtl/paddle_ctrl_pkg.sv
// Shared breakout definitions: paddle travel limits and paddle FSM state encoding.
package paddle_ctrl_pkg;

    localparam logic [9:0] PADDLE_MIN_X = 10'd4;
    localparam logic [9:0] PADDLE_MAX_X = 10'd500;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } paddle_state_e;

endpackage

// File: rtl/paddle_ctrl_debounce.sv
// Two-flop synchronizer followed by a saturating-agreement debouncer for one button.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], btn_raw};
        db_d   = db_q;
        cnt_d  = '0;
        // Flip on the edge where the count would reach DEBOUNCE_CYCLES; counter clears then.
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle movement controller: debounced buttons drive a LEFT/RIGHT FSM emitting rate-limited move strobes.
module paddle_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned MOVE_PERIOD     = 833333
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic [9:0] xPos,
    output logic       moveLeft,
    output logic       moveRight
);

    localparam int unsigned RATE_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(MOVE_PERIOD - 1);

    logic db_left, db_right;

    paddle_state_e     state_q, state_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              move_left_q, move_left_d;
    logic              move_right_q, move_right_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btnLeft),
        .btn_db  (db_left)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btnRight),
        .btn_db  (db_right)
    );

    always_comb begin
        state_d = IDLE;
        if (db_left && !db_right) begin
            state_d = LEFT;
        end else if (db_right && !db_left) begin
            state_d = RIGHT;
        end

        // Counter restarts at 0 on any state change, so a LEFT<->RIGHT swap strobes immediately.
        rate_d = '0;
        if (state_d != IDLE && state_d == state_q && rate_q != RATE_LAST) begin
            rate_d = rate_q + 1'b1;
        end

        move_left_d  = (state_d == LEFT)  && (rate_d == '0) && (xPos > PADDLE_MIN_X);
        move_right_d = (state_d == RIGHT) && (rate_d == '0) && (xPos < PADDLE_MAX_X);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rate_q       <= '0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rate_q       <= rate_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
        end
    end

    assign moveLeft  = move_left_q;
    assign moveRight = move_right_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with DEBOUNCE_CYCLES=4, MOVE_PERIOD=8 (press-to-strobe = 7 clocks).
module tb_paddle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btnLeft;
    logic       btnRight;
    logic [9:0] xPos;
    logic       moveLeft;
    logic       moveRight;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    paddle_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .MOVE_PERIOD     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btnLeft   (btnLeft),
        .btnRight  (btnRight),
        .xPos      (xPos),
        .moveLeft  (moveLeft),
        .moveRight (moveRight)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks i = first_idx..last_idx; selected output pulses at first_pulse and every 8 after.
    task automatic hold_check(input string tag, input int unsigned first_idx,
                              input int unsigned last_idx, input int unsigned first_pulse,
                              input logic want_left);
        logic pulse;
        for (int unsigned i = first_idx; i <= last_idx; i++) begin
            tick();
            pulse = (i >= first_pulse) && (((i - first_pulse) % 8) == 0);
            check($sformatf("%s_L%0d", tag, i), {31'd0, moveLeft},  {31'd0, want_left & pulse});
            check($sformatf("%s_R%0d", tag, i), {31'd0, moveRight}, {31'd0, ~want_left & pulse});
        end
    endtask

    task automatic settle(input string tag);
        btnLeft  = 1'b0;
        btnRight = 1'b0;
        repeat (10) tick();
        check({tag, "_idle_L"}, {31'd0, moveLeft},  32'd0);
        check({tag, "_idle_R"}, {31'd0, moveRight}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        btnLeft  = 1'b0;
        btnRight = 1'b0;
        xPos     = 10'd200;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check("rst_L", {31'd0, moveLeft},  32'd0);
            check("rst_R", {31'd0, moveRight}, 32'd0);
        end
        reset = 1'b0;
        tick();
        check("idle_L", {31'd0, moveLeft},  32'd0);
        check("idle_R", {31'd0, moveRight}, 32'd0);

        // Clean right press: strobes at 7, 15, 23
        btnRight = 1'b1;
        hold_check("r_hold", 1, 30, 7, 1'b0);
        settle("r_hold");

        // Left bounces every 2 clocks for 20 clocks, then held
        for (int unsigned k = 0; k < 10; k++) begin
            btnLeft = ~k[0];
            for (int unsigned j = 0; j < 2; j++) begin
                tick();
                check("bounce_L", {31'd0, moveLeft},  32'd0);
                check("bounce_R", {31'd0, moveRight}, 32'd0);
            end
        end
        btnLeft = 1'b1;
        hold_check("l_hold", 1, 24, 7, 1'b1);
        settle("l_hold");

        // Both held: nothing; release right: left strobes
        btnLeft  = 1'b1;
        btnRight = 1'b1;
        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            check("both_L", {31'd0, moveLeft},  32'd0);
            check("both_R", {31'd0, moveRight}, 32'd0);
        end
        btnRight = 1'b0;
        hold_check("both_rel", 1, 20, 7, 1'b1);
        settle("both_rel");

        // Left at the min boundary suppressed, resumes at next slot once inside
        xPos    = 10'd4;
        btnLeft = 1'b1;
        hold_check("lmin", 1, 20, 1000, 1'b1);
        xPos = 10'd5;
        hold_check("lmin_res", 21, 32, 7, 1'b1);
        settle("lmin");

        // Right at the max boundary suppressed, resumes just inside
        xPos     = 10'd500;
        btnRight = 1'b1;
        hold_check("rmax", 1, 20, 1000, 1'b0);
        xPos = 10'd499;
        hold_check("rmax_res", 21, 32, 7, 1'b0);
        settle("rmax");
        xPos = 10'd200;

        // One-cycle reset mid-hold, landing on a strobe slot
        btnRight = 1'b1;
        hold_check("rst_hold", 1, 14, 7, 1'b0);
        reset = 1'b1;
        tick();
        check("rst_mid_L", {31'd0, moveLeft},  32'd0);
        check("rst_mid_R", {31'd0, moveRight}, 32'd0);
        reset = 1'b0;
        hold_check("rst_after", 1, 20, 7, 1'b0);
        settle("rst_after");

        // Direct left->right swap: last left strobe at j=3, right from j=7
        btnLeft = 1'b1;
        hold_check("sw_left", 1, 12, 7, 1'b1);
        btnLeft  = 1'b0;
        btnRight = 1'b1;
        for (int unsigned j = 1; j <= 20; j++) begin
            tick();
            check($sformatf("sw_L%0d", j), {31'd0, moveLeft}, {31'd0, j == 3});
            check($sformatf("sw_R%0d", j), {31'd0, moveRight},
                  {31'd0, (j >= 7) && (((j - 7) % 8) == 0)});
            check("sw_excl", {31'd0, moveLeft & moveRight}, 32'd0);
        end
        settle("sw");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, consecutive clocks a synchronized button must disagree with its debounced level before that level flips.
REQ-002 Parameter MOVE_PERIOD, default 833333, clocks between successive move strobes while one button is held.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port btnLeft  input  1  raw, asynchronous, bouncing left button (1 = pressed).
REQ-006 Port btnRight  input  1  raw, asynchronous, bouncing right button (1 = pressed).
REQ-007 Port xPos  input  10  current paddle left-edge position from the paddle block, unsigned.
REQ-008 Port moveLeft  output  1  registered single-cycle strobe: paddle steps left.
REQ-009 Port moveRight  output  1  registered single-cycle strobe: paddle steps right.

Function
REQ-010 Each button SHALL pass a 2-flop synchronizer before any other logic.
REQ-011 Per button, a counter SHALL increment each cycle the synchronized level differs from the debounced level and clear on any cycle they agree.
REQ-012 The debounced level SHALL flip at the clock edge where the counter would reach DEBOUNCE_CYCLES, and the counter SHALL clear at the same edge.
REQ-013 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1); it SHALL never wrap.
REQ-014 FSM states: IDLE, LEFT, RIGHT.
REQ-015 Next state SHALL be LEFT when dbLeft=1 and dbRight=0, RIGHT when dbRight=1 and dbLeft=0, else IDLE; evaluated every cycle from any state, including LEFT<->RIGHT directly.
REQ-016 A rate counter (width clog2(MOVE_PERIOD)) SHALL be 0 on entry to LEFT or RIGHT, increment each cycle in that state, wrap from MOVE_PERIOD-1 to 0, and hold 0 in IDLE.
REQ-017 In LEFT, moveLeft SHALL be 1 exactly in cycles where the rate counter is 0, giving a strobe in the first cycle of the state and every MOVE_PERIOD cycles after.
REQ-018 RIGHT SHALL behave identically, driving moveRight.
REQ-019 moveLeft SHALL be suppressed (0) when xPos <= PADDLE_MIN_X (4); moveRight suppressed when xPos >= PADDLE_MAX_X (500); suppression SHALL not alter state or rate counter.
REQ-020 moveLeft and moveRight SHALL never both be 1 in the same cycle.
REQ-021 Both buttons held (debounced) SHALL produce IDLE and no strobes.
REQ-022 Press-to-first-strobe latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 (FSM) clocks from the first stable raw level.

Reset
REQ-023 While reset=1: synchronizer flops, debounced levels, debounce counters, rate counter 0; state IDLE; moveLeft=moveRight=0.
REQ-024 Reset asserted mid-hold SHALL drop any strobe at the next edge; after release a still-held button SHALL require full re-debounce (REQ-022) before a strobe.

Structure
REQ-025 PADDLE_MIN_X, PADDLE_MAX_X and FSM state encodings SHALL live in the shared breakout definitions include, also used by the paddle block.
REQ-026 Debounce logic (REQ-010..013) SHALL be one sub-module, button_debounce, instantiated once per button; FSM and rate counter remain in paddle_ctrl.

Verification (bench with DEBOUNCE_CYCLES=4, MOVE_PERIOD=8, xPos=200 unless stated)
REQ-027 btnRight 0->1 held clean -> first moveRight pulse 7 clocks later, then every 8 clocks; moveLeft stays 0.
REQ-028 btnLeft toggles every 2 clocks for 20 clocks then held 1 -> no strobe during bouncing; first moveLeft 7 clocks after final stable 1.
REQ-029 Both held, then btnRight released -> no strobes while both held; moveLeft fires 7 clocks after release, period 8.
REQ-030 Hold left with xPos=4, then xPos=100 -> no moveLeft at xPos=4; strobe resumes at next rate-counter 0 slot; same for right at xPos=500.
REQ-031 Hold right, assert reset 1 cycle mid-hold -> outputs 0 the cycle after reset; next moveRight 7 clocks after reset release.
REQ-032 Direct switch left-held to right-held (no gap, debounced) -> moveRight in first RIGHT cycle, counter restarted; never both strobes high.
